// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU function codes, opcodes,
// FSM states and operand-2 select.
package alu_pkg;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_BEQ  = 6'b111000;
  localparam logic [5:0] FN_BNE  = 6'b111001;
  localparam logic [5:0] FN_BLEZ = 6'b111010;
  localparam logic [5:0] FN_BGTZ = 6'b111011;
  localparam logic [5:0] FN_BGEZ = 6'b111100;
  localparam logic [5:0] FN_LUI  = 6'b111101;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  typedef enum logic [1:0] {SEL_RT, SEL_ZEXT, SEL_SEXT} in2_sel_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: instruction fields to ALU func, operand-2
// select, destination and branch/illegal flags. ALU_MULDIV_EN enables mult/div.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  output logic [5:0] func,
  output in2_sel_t   in2_sel,
  output logic [4:0] dest,
  output logic       is_branch,
  output logic       illegal
);

  // Illegal instructions keep the ADDU code so alu_func never carries garbage.
  always_comb begin
    func      = FN_ADDU;
    in2_sel   = SEL_RT;
    dest      = 5'd0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_XOR, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SUB, FN_SUBU,
          FN_SLT, FN_OR, FN_NOR, FN_ADDU, FN_AND: begin
            func = funct;
            dest = rd;
          end
`ifdef ALU_MULDIV_EN
          FN_MULT, FN_DIV: begin
            func = funct;
            dest = rd;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BGEZ) begin
          func      = FN_BGEZ;
          is_branch = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BEQ: begin
        func      = FN_BEQ;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        func      = FN_BNE;
        is_branch = 1'b1;
      end
      OP_BLEZ: begin
        func      = FN_BLEZ;
        is_branch = 1'b1;
      end
      OP_BGTZ: begin
        func      = FN_BGTZ;
        is_branch = 1'b1;
      end
      OP_LUI: begin
        func    = FN_LUI;
        in2_sel = SEL_ZEXT;
        dest    = rt;
      end
      OP_ADDIU: begin
        func    = FN_ADDU;
        in2_sel = SEL_SEXT;
        dest    = rt;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Multi-cycle issue controller: accept, decode, execute on the external ALU,
// then emit one writeback/branch/illegal pulse. ALU_MULDIV_EN enables mult/div.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic        br_taken,
  output logic [31:0] br_offset,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [31:0] instr_q, rs_q, rt_q;
  logic        wb_en_q, br_q, ill_q;

  logic [5:0]  dec_func;
  in2_sel_t    dec_in2_sel;
  logic [4:0]  dec_dest;
  logic        dec_branch, dec_illegal;
  logic [15:0] imm;
  logic [31:0] in2_d;
  logic        taken_d;

  // alu_zero is deliberately ignored and the rs field is already resolved
  // into rs_data by the register file.
  logic unused_ok;
  assign unused_ok = ^{alu_zero, instr_q[25:21]};

  assign imm = instr_q[15:0];

  alu_decode u_decode (
    .opcode    (instr_q[31:26]),
    .rt        (instr_q[20:16]),
    .rd        (instr_q[15:11]),
    .funct     (instr_q[5:0]),
    .func      (dec_func),
    .in2_sel   (dec_in2_sel),
    .dest      (dec_dest),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
    wb_valid    = (state_q == WB) && wb_en_q;
    br_valid    = (state_q == WB) && br_q;
    illegal     = (state_q == WB) && ill_q;
  end

  always_comb begin
    in2_d = rt_q;
    if (dec_in2_sel == SEL_ZEXT)      in2_d = {16'h0000, imm};
    else if (dec_in2_sel == SEL_SEXT) in2_d = {{16{imm[15]}}, imm};
  end

  // Branches resolve here with signed compares instead of via the ALU.
  always_comb begin
    taken_d = 1'b0;
    case (dec_func)
      FN_BEQ:  taken_d = (rs_q == rt_q);
      FN_BNE:  taken_d = (rs_q != rt_q);
      FN_BLEZ: taken_d = ($signed(rs_q) <= 32'sd0);
      FN_BGTZ: taken_d = ($signed(rs_q) >  32'sd0);
      FN_BGEZ: taken_d = ($signed(rs_q) >= 32'sd0);
      default: taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_func  <= FN_ADDU;
      wb_reg    <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_offset <= '0;
      wb_en_q   <= 1'b0;
      br_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            rs_q    <= rs_data;
            rt_q    <= rt_data;
          end
        end
        DECODE: begin
          alu_func  <= dec_func;
          alu_in1   <= rs_q;
          alu_in2   <= in2_d;
          wb_reg    <= dec_dest;
          br_taken  <= taken_d;
          br_offset <= {{14{imm[15]}}, imm, 2'b00};
          wb_en_q   <= !dec_illegal && !dec_branch && (dec_dest != 5'd0);
          br_q      <= dec_branch;
          ill_q     <= dec_illegal;
        end
        EXEC:    wb_data <= alu_out;
        default: ;
      endcase
    end
  end

endmodule
